// File: rtl/enigma_flag_encoder.sv
// enigma_flag_encoder
//   Single-rotor Enigma front end for the bombe. Collects FLAG_LEN uppercase
//   plaintext chars, Caesar-shifts each by a stepping rotor, buffers the
//   ciphertext, then replays it as timed press/release key events.
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   start       begin a new flag (honoured in IDLE/DONE), latches rotor_init
//   rotor_init  initial rotor position (26..31 reduced by 26)
//   char_in     ASCII plaintext character
//   char_valid  char_in valid this cycle
//   char_ready  char accepted this cycle (LOAD only)
//   bad_char    1-cycle pulse after an accepted non 'A'..'Z' char
//   char_out    ciphertext char presented to the bombe
//   key_press   key-press indicator to the bombe
//   busy        high in LOAD, PRESS, RELEASE
//   done        high once the full flag has been replayed
module enigma_flag_encoder #(
    parameter int unsigned FLAG_LEN       = 3,
    parameter int unsigned PRESS_CYCLES   = 4,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] rotor_init,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       bad_char,
    output logic [7:0] char_out,
    output logic       key_press,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRESS,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [2:0]  LAST_IDX     = 3'(FLAG_LEN - 1);
    localparam logic [15:0] PRESS_LAST   = 16'(PRESS_CYCLES - 1);
    localparam logic [15:0] RELEASE_LAST = 16'(RELEASE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  rotor_q, rotor_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        bad_q, bad_d;
    // Sized for the maximum FLAG_LEN so a 3-bit index always fits.
    logic [7:0]  buf_q [0:7];
    logic        buf_we;
    logic [7:0]  buf_wdata;

    logic       letter_ok;
    logic [4:0] letter_off;
    logic [5:0] sum6;
    logic [5:0] sum_red;
    logic [4:0] init_red;

    // 'A'..'Z' are 0x41..0x5A, so the low five bits minus one give 0..25.
    assign letter_ok  = (char_in >= 8'd65) && (char_in <= 8'd90);
    assign letter_off = char_in[4:0] - 5'd1;
    assign sum6       = {1'b0, letter_off} + {1'b0, rotor_q};
    assign sum_red    = (sum6 >= 6'd26) ? sum6 - 6'd26 : sum6;
    assign buf_wdata  = 8'd65 + {2'b00, sum_red};
    assign init_red   = (rotor_init >= 5'd26) ? rotor_init - 5'd26 : rotor_init;

    always_comb begin
        state_d = state_q;
        rotor_d = rotor_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        bad_d   = 1'b0;
        buf_we  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    rotor_d = init_red;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (char_valid) begin
                    if (letter_ok) begin
                        buf_we  = 1'b1;
                        rotor_d = (rotor_q == 5'd25) ? 5'd0 : rotor_q + 5'd1;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_PRESS;
                            idx_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            S_PRESS: begin
                if (cnt_q == PRESS_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RELEASE: begin
                if (cnt_q == RELEASE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PRESS;
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rotor_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rotor_q <= rotor_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            if (buf_we) begin
                buf_q[idx_q] <= buf_wdata;
            end
        end
    end

    assign char_ready = (state_q == S_LOAD);
    assign bad_char   = bad_q;
    assign key_press  = (state_q == S_PRESS);
    assign busy       = (state_q == S_LOAD) || (state_q == S_PRESS) || (state_q == S_RELEASE);
    assign done       = (state_q == S_DONE);
    assign char_out   = ((state_q == S_PRESS) || (state_q == S_RELEASE) || (state_q == S_DONE))
                        ? buf_q[idx_q] : 8'd0;

endmodule

// File: tb/tb_enigma_flag_encoder.sv
module tb_enigma_flag_encoder;

    logic       clk = 1'b0;
    logic       reset, start, char_valid;
    logic [4:0] rotor_init;
    logic [7:0] char_in;
    logic       char_ready, bad_char, key_press, busy, done;
    logic [7:0] char_out;

    int checks   = 0;
    int failures = 0;

    enigma_flag_encoder #(
        .FLAG_LEN(3),
        .PRESS_CYCLES(4),
        .RELEASE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rotor_init(rotor_init),
        .char_in(char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .bad_char(bad_char),
        .char_out(char_out),
        .key_press(key_press),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]       rot;
        int unsigned      n;
        logic [7:0][7:0]  ch;
        logic [7:0]       bad;
        logic [2:0][7:0]  exp;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input logic [4:0] r, input int unsigned n,
                                input logic [7:0] c0, input logic [7:0] c1,
                                input logic [7:0] c2, input logic [7:0] c3,
                                input logic [7:0] c4, input logic [7:0] bm,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2);
        vec_t v;
        v        = '0;
        v.rot    = r;
        v.n      = n;
        v.ch[0]  = c0;
        v.ch[1]  = c1;
        v.ch[2]  = c2;
        v.ch[3]  = c3;
        v.ch[4]  = c4;
        v.bad    = bm;
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rotor, count, chars, bad-mask (bit i = char i invalid), expected ciphertext
        vecs[0] = mk(5'd0,  3, "A", "B", "C", 8'd0, 8'd0, 8'b00000, 8'd65, 8'd67, 8'd69);
        vecs[1] = mk(5'd25, 3, "A", "B", "C", 8'd0, 8'd0, 8'b00000, 8'd90, 8'd66, 8'd68);
        vecs[2] = mk(5'd3,  5, "a", "A", "#", "B", "C",   8'b00101, 8'd68, 8'd70, 8'd72);
        vecs[3] = mk(5'd30, 3, "X", "Y", "Z", 8'd0, 8'd0, 8'b00000, 8'd66, 8'd68, 8'd70);
        vecs[4] = mk(5'd31, 3, "Z", "Z", "Z", 8'd0, 8'd0, 8'b00000, 8'd69, 8'd70, 8'd71);
        vecs[5] = mk(5'd7,  3, "A", "B", "C", 8'd0, 8'd0, 8'b00000, 8'd72, 8'd74, 8'd76);

        reset      = 1'b1;
        start      = 1'b0;
        char_valid = 1'b0;
        rotor_init = '0;
        char_in    = '0;
        tick();
        tick();
        chk("rst_ready", char_ready, 0);
        chk("rst_bad",   bad_char, 0);
        chk("rst_out",   char_out, 0);
        chk("rst_key",   key_press, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        reset = 1'b0;

        // char_valid outside LOAD is ignored and never flags bad_char
        char_valid = 1'b1;
        char_in    = "#";
        tick();
        chk("idle_bad",   bad_char, 0);
        chk("idle_ready", char_ready, 0);
        chk("idle_busy",  busy, 0);
        char_valid = 1'b0;

        foreach (vecs[v]) begin
            // char presented alongside start must not be taken
            rotor_init = vecs[v].rot;
            start      = 1'b1;
            char_valid = 1'b1;
            char_in    = "Q";
            tick();
            start      = 1'b0;
            char_valid = 1'b0;
            chk("load_ready", char_ready, 1);
            chk("load_busy",  busy, 1);
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                char_in    = vecs[v].ch[i];
                char_valid = 1'b1;
                tick();
                chk("bad_pulse", bad_char, vecs[v].bad[i]);
            end
            char_valid = 1'b0;
            for (int c = 0; c < 24; c++) begin
                chk("key",     key_press, ((c % 8) < 4) ? 1 : 0);
                chk("out",     char_out, vecs[v].exp[c / 8]);
                chk("busy",    busy, 1);
                chk("no_bad",  bad_char, 0);
                if (c == 2) begin
                    start      = 1'b1;
                    char_valid = 1'b1;
                    char_in    = "#";
                end
                tick();
                start      = 1'b0;
                char_valid = 1'b0;
            end
            chk("fin_done", done, 1);
            chk("fin_busy", busy, 0);
            chk("fin_key",  key_press, 0);
            chk("fin_out",  char_out, vecs[v].exp[2]);
        end

        // reset during the second PRESS aborts at once
        rotor_init = 5'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        foreach (vecs[0].exp[i]) begin
            char_in    = (i == 0) ? "A" : (i == 1) ? "B" : "C";
            char_valid = 1'b1;
            tick();
        end
        char_valid = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        chk("mid_key", key_press, 1);
        chk("mid_out", char_out, 67);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("abort_key",   key_press, 0);
        chk("abort_out",   char_out, 0);
        chk("abort_busy",  busy, 0);
        chk("abort_done",  done, 0);
        chk("abort_ready", char_ready, 0);
        for (int c = 0; c < 10; c++) tick();
        chk("abort_stay_key",   key_press, 0);
        chk("abort_stay_ready", char_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
